// File: rtl/charmap_writer.sv
// charmap_writer
//   Turns a stream of character codes from the processor's text-print state
//   into writes to a character-map RAM. It keeps a text cursor, blanks each
//   new row as the cursor enters it, handles newline, backspace and
//   form-feed, and buffers incoming characters in a small FIFO while a row
//   or screen clear is running.
//
// Parameters
//   COLS  - text columns per row
//   ROWS  - text rows
//   DEPTH - character FIFO entries (power of two)
//
// Ports
//   clk        in   sole clock, rising edge
//   reset      in   asynchronous, active-high reset
//   textprint  in   one-cycle pulse, char_in valid this cycle
//   char_in    in   [7:0] character code
//   vram_we    out  character-map RAM write strobe
//   vram_addr  out  [11:0] cell address = row*COLS + col
//   vram_wdata out  [7:0] character written to the cell
//   cursor_row out  [4:0] current cursor row
//   cursor_col out  [6:0] current cursor column
//   busy       out  FSM not idle or FIFO non-empty
//   overflow   out  sticky: a character was dropped on a full FIFO
module charmap_writer #(
  parameter int COLS  = 80,
  parameter int ROWS  = 30,
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        textprint,
  input  logic [7:0]  char_in,
  output logic        vram_we,
  output logic [11:0] vram_addr,
  output logic [7:0]  vram_wdata,
  output logic [4:0]  cursor_row,
  output logic [6:0]  cursor_col,
  output logic        busy,
  output logic        overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0]   FIFO_FULL = DEPTH[PW:0];
  localparam logic [PW:0]   CNT_ONE   = 1;
  localparam logic [PW-1:0] PTR_ONE   = 1;
  localparam logic [6:0]    COL_LAST  = 7'(COLS - 1);
  localparam logic [4:0]    ROW_LAST  = 5'(ROWS - 1);
  localparam logic [11:0]   CELL_LAST = 12'(ROWS * COLS - 1);
  localparam logic [7:0]    BLANK     = 8'h20;

  typedef enum logic [1:0] {IDLE, WRITE, ROWCLR, CLEAR} state_t;

  state_t state, state_nxt;

  logic [7:0]    fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          push, pop;
  logic [7:0]    head;

  // Pending write cell/data, row-clear progress and backspace marker
  logic [11:0] addr_q, addr_nxt;
  logic [7:0]  data_q, data_nxt;
  logic [6:0]  clr_cnt, clr_cnt_nxt;
  logic        bs_q, bs_nxt;
  logic [4:0]  row_nxt;
  logic [6:0]  col_nxt;

  function automatic logic [4:0] next_row(input logic [4:0] r);
    return (r == ROW_LAST) ? 5'd0 : r + 5'd1;
  endfunction

  function automatic logic [11:0] row_base(input logic [4:0] r);
    return 12'(r) * 12'(COLS);
  endfunction

  assign head = fifo_mem[rd_ptr];
  // A full FIFO still accepts a push when the head is popped the same cycle
  assign push = textprint && ((count != FIFO_FULL) || pop);
  assign busy = (state != IDLE) || (count != '0);

  always_comb begin
    state_nxt   = state;
    addr_nxt    = addr_q;
    data_nxt    = data_q;
    clr_cnt_nxt = clr_cnt;
    bs_nxt      = bs_q;
    row_nxt     = cursor_row;
    col_nxt     = cursor_col;
    pop         = 1'b0;
    vram_we     = 1'b0;
    vram_addr   = '0;
    vram_wdata  = '0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop = 1'b1;
          if (head >= 8'h20 && head <= 8'h7E) begin
            state_nxt = WRITE;
            addr_nxt  = row_base(cursor_row) + 12'(cursor_col);
            data_nxt  = head;
            bs_nxt    = 1'b0;
          end else if (head == 8'h0A) begin
            state_nxt   = ROWCLR;
            col_nxt     = '0;
            row_nxt     = next_row(cursor_row);
            addr_nxt    = row_base(next_row(cursor_row));
            data_nxt    = BLANK;
            clr_cnt_nxt = '0;
          end else if (head == 8'h08) begin
            if (cursor_col != '0) begin
              state_nxt = WRITE;
              col_nxt   = cursor_col - 7'd1;
              addr_nxt  = row_base(cursor_row) + 12'(cursor_col) - 12'd1;
              data_nxt  = BLANK;
              bs_nxt    = 1'b1;
            end
          end else if (head == 8'h0C) begin
            state_nxt = CLEAR;
            addr_nxt  = '0;
            data_nxt  = BLANK;
          end
        end
      end
      WRITE: begin
        vram_we    = 1'b1;
        vram_addr  = addr_q;
        vram_wdata = data_q;
        state_nxt  = IDLE;
        // Backspace already moved the cursor when it was decoded
        if (!bs_q) begin
          if (cursor_col == COL_LAST) begin
            state_nxt   = ROWCLR;
            col_nxt     = '0;
            row_nxt     = next_row(cursor_row);
            addr_nxt    = row_base(next_row(cursor_row));
            data_nxt    = BLANK;
            clr_cnt_nxt = '0;
          end else begin
            col_nxt = cursor_col + 7'd1;
          end
        end
      end
      ROWCLR: begin
        vram_we    = 1'b1;
        vram_addr  = addr_q;
        vram_wdata = data_q;
        if (clr_cnt == COL_LAST) begin
          state_nxt = IDLE;
        end else begin
          clr_cnt_nxt = clr_cnt + 7'd1;
          addr_nxt    = addr_q + 12'd1;
        end
      end
      CLEAR: begin
        vram_we    = 1'b1;
        vram_addr  = addr_q;
        vram_wdata = data_q;
        if (addr_q == CELL_LAST) begin
          state_nxt = IDLE;
          row_nxt   = '0;
          col_nxt   = '0;
        end else begin
          addr_nxt = addr_q + 12'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      cursor_row <= '0;
      cursor_col <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      clr_cnt    <= '0;
      bs_q       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cursor_row <= row_nxt;
      cursor_col <= col_nxt;
      addr_q     <= addr_nxt;
      data_q     <= data_nxt;
      clr_cnt    <= clr_cnt_nxt;
      bs_q       <= bs_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (textprint && !push) overflow <= 1'b1;
    end
  end

  // FIFO storage carries data only; occupancy and pointers define validity
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= char_in;
  end

endmodule

// File: tb/tb_charmap_writer.sv
// tb_charmap_writer
//   Directed bench for charmap_writer. A screen-level model turns each
//   accepted character into the list of cell writes it must cause; a compare
//   process matches every DUT write and the overflow flag against it, and
//   literal checks pin cursor positions, latency and selected cells.
module tb_charmap_writer;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int DEPTH = 8;
  localparam int CELLS = COLS * ROWS;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        textprint = 1'b0;
  logic [7:0]  char_in = 8'h00;
  logic        vram_we;
  logic [11:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic [4:0]  cursor_row;
  logic [6:0]  cursor_col;
  logic        busy;
  logic        overflow;

  charmap_writer #(.COLS(COLS), .ROWS(ROWS), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .textprint(textprint), .char_in(char_in),
    .vram_we(vram_we), .vram_addr(vram_addr), .vram_wdata(vram_wdata),
    .cursor_row(cursor_row), .cursor_col(cursor_col),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] addr;
    logic [7:0]  data;
  } wr_t;

  int   total = 0;
  int   bad = 0;
  wr_t  expq[$];
  int   m_row = 0;
  int   m_col = 0;
  logic m_ovf = 1'b0;
  int   nwrites = 0;
  logic [7:0] shadow [CELLS];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic void push_wr(input int a, input logic [7:0] d);
    wr_t w;
    w.addr = 12'(a);
    w.data = d;
    expq.push_back(w);
  endfunction

  function automatic void blank_row(input int r);
    for (int i = 0; i < COLS; i++) push_wr(r * COLS + i, 8'h20);
  endfunction

  // Screen-level effect of one accepted character
  function automatic void model_char(input logic [7:0] c);
    if (c >= 8'h20 && c <= 8'h7E) begin
      push_wr(m_row * COLS + m_col, c);
      m_col++;
      if (m_col == COLS) begin
        m_col = 0;
        m_row = (m_row + 1) % ROWS;
        blank_row(m_row);
      end
    end else if (c == 8'h0A) begin
      m_col = 0;
      m_row = (m_row + 1) % ROWS;
      blank_row(m_row);
    end else if (c == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        push_wr(m_row * COLS + m_col, 8'h20);
      end
    end else if (c == 8'h0C) begin
      for (int i = 0; i < CELLS; i++) push_wr(i, 8'h20);
      m_row = 0;
      m_col = 0;
    end
  endfunction

  function automatic void model_reset();
    expq.delete();
    m_row = 0;
    m_col = 0;
    m_ovf = 1'b0;
  endfunction

  always @(negedge clk) begin : compare
    wr_t w;
    if (!reset) begin
      chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
      if (vram_we) begin
        nwrites++;
        if (int'(vram_addr) < CELLS) shadow[vram_addr] = vram_wdata;
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got addr %0d data %0h want no write", vram_addr, vram_wdata);
        end else begin
          w = expq.pop_front();
          chk("wr_addr", {20'd0, vram_addr}, {20'd0, w.addr});
          chk("wr_data", {24'd0, vram_wdata}, {24'd0, w.data});
        end
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the pulse
  task automatic send(input logic [7:0] c, input bit drop);
    textprint = 1'b1;
    char_in   = c;
    @(posedge clk);
    if (drop) m_ovf = 1'b1;
    else      model_char(c);
    @(negedge clk);
    textprint = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: busy got 1 want 0", name);
    end
    @(negedge clk);
    chk({name, "_row"}, cursor_row, m_row);
    chk({name, "_col"}, cursor_col, m_col);
    chk({name, "_pending"}, expq.size(), 0);
  endtask

  task automatic print(input logic [7:0] c);
    send(c, 1'b0);
    wait_idle("print");
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n0;
    for (int i = 0; i < CELLS; i++) shadow[i] = 8'hFF;

    // Reset values while reset is held
    repeat (2) @(negedge clk);
    chk("rst_we", vram_we, 0);
    chk("rst_addr", vram_addr, 0);
    chk("rst_wdata", vram_wdata, 0);
    chk("rst_row", cursor_row, 0);
    chk("rst_col", cursor_col, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    reset = 1'b0;
    @(negedge clk);

    // Single 'A': write strobe two cycles after the pulse
    send(8'h41, 1'b0);
    chk("a_t1_we", vram_we, 0);
    @(negedge clk);
    chk("a_t2_we", vram_we, 1);
    chk("a_t2_addr", vram_addr, 12'h000);
    chk("a_t2_data", vram_wdata, 8'h41);
    @(negedge clk);
    chk("a_t3_busy", busy, 0);
    chk("a_t3_row", cursor_row, 0);
    chk("a_t3_col", cursor_col, 1);
    wait_idle("a");

    // Non-printable control code: consumed silently
    n0 = nwrites;
    print(8'h01);
    chk("ctl_nowrite", nwrites, n0);
    chk("ctl_col", cursor_col, 1);

    // Full row from (0,0): wrap into row 1 and blank it
    do_reset();
    for (int i = 0; i < 79; i++) begin
      send(8'h61 + 8'(i % 26), 1'b0);
      @(negedge clk);
    end
    send(8'h5A, 1'b0);
    wait_idle("row");
    chk("row_end_row", cursor_row, 1);
    chk("row_end_col", cursor_col, 0);
    chk("row_z_cell", shadow[79], 8'h5A);
    chk("row_blank80", shadow[80], 8'h20);
    chk("row_blank159", shadow[159], 8'h20);
    chk("row_untouched160", shadow[160], 8'hFF);

    // Backspace at column 0 and mid-row
    print(8'h0A);
    print(8'h0A);
    chk("bs0_pre_row", cursor_row, 3);
    n0 = nwrites;
    print(8'h08);
    chk("bs0_nowrite", nwrites, n0);
    chk("bs0_col", cursor_col, 0);
    print(8'h61); print(8'h62); print(8'h63); print(8'h64);
    chk("bs4_cell_pre", shadow[243], 8'h64);
    print(8'h08);
    chk("bs4_row", cursor_row, 3);
    chk("bs4_col", cursor_col, 3);
    chk("bs4_cell", shadow[243], 8'h20);

    // Newline from the last row wraps to row 0
    for (int i = 0; i < 26; i++) print(8'h0A);
    for (int i = 0; i < 5; i++) print(8'h30 + 8'(i));
    chk("nl_pre_row", cursor_row, 29);
    chk("nl_pre_col", cursor_col, 5);
    print(8'h0A);
    chk("nl_row", cursor_row, 0);
    chk("nl_col", cursor_col, 0);
    chk("nl_cell0", shadow[0], 8'h20);
    chk("nl_cell79", shadow[79], 8'h20);

    // Form feed with nine characters arriving during the clear
    send(8'h0C, 1'b0);
    for (int i = 0; i < 9; i++) begin
      repeat (2) @(negedge clk);
      if (i == 8) chk("ff_ovf_before", overflow, 0);
      send(8'h30 + 8'(i), i == 8);
    end
    chk("ff_ovf_after", overflow, 1);
    wait_idle("ff");
    chk("ff_row", cursor_row, 0);
    chk("ff_col", cursor_col, 8);
    chk("ff_cell7", shadow[7], 8'h37);
    chk("ff_cell8", shadow[8], 8'h20);
    chk("ff_cell2399", shadow[2399], 8'h20);

    // Asynchronous reset in the middle of a clear
    send(8'h0C, 1'b0);
    repeat (100) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    chk("ar_we", vram_we, 0);
    chk("ar_addr", vram_addr, 0);
    chk("ar_wdata", vram_wdata, 0);
    chk("ar_row", cursor_row, 0);
    chk("ar_col", cursor_col, 0);
    chk("ar_busy", busy, 0);
    chk("ar_ovf", overflow, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    print(8'h51);
    chk("ar_next_cell", shadow[0], 8'h51);
    chk("ar_next_col", cursor_col, 1);
    chk("end_pending", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/charmap_writer.md
CHARMAP_WRITER -- requirements
Module: charmap_writer

Interface
REQ-001 SHALL have parameter COLS, default 80, meaning text columns per row.
REQ-002 SHALL have parameter ROWS, default 30, meaning text rows.
REQ-003 SHALL have parameter DEPTH, default 8, meaning character FIFO entries (power of two).
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port textprint  input  1  one-cycle pulse from the processor text-print state; char_in is valid this cycle.
REQ-007 SHALL have port char_in  input  8  character code (processor writedata[7:0]).
REQ-008 SHALL have port vram_we  output  1  character-map RAM write strobe.
REQ-009 SHALL have port vram_addr  output  12  cell address = row*COLS + col.
REQ-010 SHALL have port vram_wdata  output  8  character written to the cell.
REQ-011 SHALL have port cursor_row  output  5  current cursor row.
REQ-012 SHALL have port cursor_col  output  7  current cursor column.
REQ-013 SHALL have port busy  output  1  high when state != IDLE or FIFO non-empty.
REQ-014 SHALL have port overflow  output  1  sticky flag: a character was dropped.

Function
REQ-015 SHALL push char_in into the FIFO on every clk edge where textprint=1 and the FIFO is not full, or is full and pops in the same cycle.
REQ-016 SHALL drop char_in and set overflow when textprint=1, the FIFO holds DEPTH entries, and no pop occurs that cycle; overflow clears only on reset.
REQ-017 SHALL implement FSM states IDLE, WRITE, ROWCLR and CLEAR.
REQ-018 In IDLE with the FIFO non-empty, the block SHALL pop the head entry and decode it in the same cycle.
REQ-019 For printable codes 0x20..0x7E, the block SHALL go to WRITE and, in the following cycle, assert vram_we for exactly one cycle with vram_addr = cursor cell and vram_wdata = code.
REQ-020 After a printable write it SHALL advance col; at col = COLS-1 it SHALL set col to 0, advance row, and enter ROWCLR.
REQ-021 Row advance from ROWS-1 SHALL wrap to row 0; there is no scrolling.
REQ-022 Code 0x0A (newline) SHALL set col=0, advance row with wrap, and enter ROWCLR.
REQ-023 Code 0x08 (backspace) at col > 0 SHALL decrement col and write 0x20 at the new cell through WRITE; at col=0 it SHALL be a no-op.
REQ-024 Code 0x0C (form feed) SHALL enter CLEAR and set the cursor to (0,0) on completion.
REQ-025 All other codes SHALL be consumed with no RAM write and no cursor change; the FSM stays in IDLE.
REQ-026 ROWCLR SHALL write 0x20 to the COLS cells of the new row, ascending col, one per cycle, then return to IDLE.
REQ-027 CLEAR SHALL write 0x20 to all ROWS*COLS cells, address 0 upward, one per cycle, then return to IDLE.
REQ-028 vram_we SHALL be high only in WRITE, ROWCLR and CLEAR; vram_addr and vram_wdata are don't-care while vram_we = 0.
REQ-029 The FIFO SHALL keep accepting pushes during ROWCLR and CLEAR; pops occur only in IDLE.
REQ-030 Minimum latency for a printable character SHALL be: textprint at cycle T, popped at T+1, vram_we high during T+2.
REQ-031 FIFO pointers SHALL wrap modulo DEPTH; full and empty SHALL be distinguished by an occupancy count 0..DEPTH.

Reset
REQ-032 Reset SHALL act immediately and asynchronously, aborting any WRITE, ROWCLR or CLEAR in progress.
REQ-033 While reset is high, the outputs SHALL be: state IDLE, FIFO empty, cursor (0,0), vram_we=0, vram_addr=0, vram_wdata=0, busy=0, overflow=0.
REQ-034 Reset SHALL NOT clear RAM contents.

Verification
REQ-035 Print 'A' (0x41) after reset -> single vram_we pulse at T+2, addr 0, data 0x41; cursor ends at (0,1); busy low again by T+3.
REQ-036 Print 79 printable chars, then 'Z' -> 'Z' written at addr 79; then 80 writes of 0x20 at addr 80..159; cursor ends at (1,0).
REQ-037 Cursor at (29,5) then 0x0A -> cursor (0,0); 0x20 written to addr 0..79.
REQ-038 0x0C followed immediately by 9 textprint pulses 3 cycles apart -> 2400 writes of 0x20 (addr 0..2399); first 8 chars buffered and written afterwards from (0,0); 9th dropped only if FIFO full at arrival; overflow asserted exactly then.
REQ-039 Backspace at (3,0) -> no write, cursor stays (3,0); backspace at (3,4) -> 0x20 written at addr 243, cursor becomes (3,3).
REQ-040 Reset asserted in the middle of CLEAR -> vram_we low in the same cycle, cursor (0,0), FIFO empty; next printable char is written at addr 0.
